ahb_flash_reader: RTL and testbench

- AHB-Lite read-only slave that fetches one 32-bit word per transfer from external quad-SPI flash.
- Uses Fast Read Quad I/O (0xEB).
- Its flash pins form the "FR" side that the bit-bang flash writer muxes onto the flash in normal (non-programming) mode.
- Serves execute-in-place and data reads. No cache, no prefetch; each access is a complete CE-framed flash transaction.

---
 rtl/flash_pkg.sv | 44 ++++
 rtl/ahb_flash_reader.sv | 141 ++++++++++++++
 tb/tb_ahb_flash_reader.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/flash_pkg.sv
// Shared definitions for the quad-SPI flash reader/writer pair: FSM states,
// the flash command and the nibble counts of each transaction phase.
package flash_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StMode,
        StDummy,
        StData,
        StDone
    } state_e;

    localparam logic [7:0]  CMD_QUAD_IO_READ = 8'hEB;
    localparam int unsigned CMD_BITS         = 8;
    localparam int unsigned ADDR_NIBBLES     = 6;
    localparam int unsigned MODE_NIBBLES     = 2;
    localparam int unsigned DATA_NIBBLES     = 8;

    // Value of the bit counter in the final bit period of each flash phase.
    function automatic logic [3:0] last_count(input state_e st, input logic [3:0] dummy_last);
        case (st)
            StCmd:   return 4'(CMD_BITS - 1);
            StAddr:  return 4'(ADDR_NIBBLES - 1);
            StMode:  return 4'(MODE_NIBBLES - 1);
            StDummy: return dummy_last;
            StData:  return 4'(DATA_NIBBLES - 1);
            default: return 4'd0;
        endcase
    endfunction

    function automatic state_e next_phase(input state_e st);
        case (st)
            StCmd:   return StAddr;
            StAddr:  return StMode;
            StMode:  return StDummy;
            StDummy: return StData;
            StData:  return StDone;
            default: return StIdle;
        endcase
    endfunction

endpackage

// File: rtl/ahb_flash_reader.sv
// AHB-Lite read-only slave: each read is one CE-framed Fast Read Quad I/O (0xEB)
// flash transaction returning a 32-bit little-endian word. Writes complete at once.
module ahb_flash_reader
    import flash_pkg::*;
#(
    parameter int unsigned DUMMY_CLKS = 4,
    parameter logic [7:0]  MODE_BYTE  = 8'h00
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA,
    output logic        fr_sck,
    output logic        fr_ce_n,
    input  logic [3:0]  fr_din,
    output logic [3:0]  fr_dout,
    output logic        fr_douten
);

    localparam logic [3:0] DummyLast = 4'(DUMMY_CLKS - 1);

    state_e      state_q, state_d;
    logic        phase_q, phase_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [23:0] addr_q, addr_d;
    logic [31:0] shift_q, shift_d;
    logic [31:0] hrdata_q, hrdata_d;
    logic        sck_q, sck_d;
    logic        ce_n_q, ce_n_d;
    logic [3:0]  dout_q, dout_d;
    logic        douten_q, douten_d;
    logic        hready_q, hready_d;

    logic        accept;
    logic        active_d;
    logic [4:0]  nib_pos;

    assign accept  = HSEL & HTRANS[1] & HREADY & ~HWRITE;
    // Nibble k lands in byte k/2, high nibble first.
    assign nib_pos = {cnt_q[2:1], ~cnt_q[0], 2'b00};

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        shift_d  = shift_q;
        hrdata_d = hrdata_q;

        case (state_q)
            StIdle, StDone: begin
                phase_d = 1'b0;
                cnt_d   = 4'd0;
                state_d = accept ? StCmd : StIdle;
                if (accept) begin
                    addr_d = {HADDR[23:2], 2'b00};
                end
            end
            default: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    if (state_q == StData) begin
                        shift_d[nib_pos +: 4] = fr_din;
                    end
                    if (cnt_q == last_count(state_q, DummyLast)) begin
                        cnt_d   = 4'd0;
                        state_d = next_phase(state_q);
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
        endcase

        if (state_q == StData && state_d == StDone) begin
            hrdata_d = shift_d;
        end

        // Pin values are decoded from the next state so they change on phase0 entry.
        active_d = !(state_d == StIdle || state_d == StDone);
        sck_d    = phase_d & active_d;
        ce_n_d   = ~active_d;
        hready_d = ~active_d;
        douten_d = (state_d == StCmd) || (state_d == StAddr) || (state_d == StMode);

        case (state_d)
            StCmd:   dout_d = {3'b111, CMD_QUAD_IO_READ[3'(4'd7 - cnt_d)]};
            StAddr:  dout_d = addr_d[5'd20 - {cnt_d[2:0], 2'b00} +: 4];
            StMode:  dout_d = cnt_d[0] ? MODE_BYTE[3:0] : MODE_BYTE[7:4];
            default: dout_d = 4'hF;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= StIdle;
            phase_q  <= 1'b0;
            cnt_q    <= 4'd0;
            addr_q   <= 24'd0;
            shift_q  <= 32'd0;
            hrdata_q <= 32'd0;
            sck_q    <= 1'b0;
            ce_n_q   <= 1'b1;
            dout_q   <= 4'hF;
            douten_q <= 1'b0;
            hready_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            shift_q  <= shift_d;
            hrdata_q <= hrdata_d;
            sck_q    <= sck_d;
            ce_n_q   <= ce_n_d;
            dout_q   <= dout_d;
            douten_q <= douten_d;
            hready_q <= hready_d;
        end
    end

    assign HREADYOUT = hready_q;
    assign HRESP     = 1'b0;
    assign HRDATA    = hrdata_q;
    assign fr_sck    = sck_q;
    assign fr_ce_n   = ce_n_q;
    assign fr_dout   = dout_q;
    assign fr_douten = douten_q;

    logic unused_ok;
    assign unused_ok = ^{HADDR[31:24], HADDR[1:0], HTRANS[0], HSIZE, HWDATA};

endmodule

// File: tb/tb_ahb_flash_reader.sv
// Bench for ahb_flash_reader: two instances (4 and 8 dummy clocks), each with a
// behavioural quad-SPI flash, checked every cycle against a cycle-count bus/pin model.
module tb_ahb_flash_reader;

    localparam logic [7:0] TbMode = 8'h00;

    logic        HCLK;
    logic        HRESETn;
    logic [1:0]  hsel;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic [1:0]  hreadyout;
    logic [1:0]  hresp;
    logic [31:0] hrdata [2];
    logic [1:0]  sck;
    logic [1:0]  ce_n;
    logic [1:0]  douten;

    int          n_cmp;
    int          n_bad;
    int          left [2];
    int          W [2];
    logic [23:0] pend_addr [2];
    logic [31:0] pend_word [2];
    logic [31:0] last_word [2];

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Flash contents: a fixed pattern, with the test word 11 22 33 44 at 0x1234.
    function automatic logic [7:0] mem(input logic [23:0] b);
        case (b)
            24'h001234: return 8'h11;
            24'h001235: return 8'h22;
            24'h001236: return 8'h33;
            24'h001237: return 8'h44;
            default:    return b[7:0] ^ b[15:8] ^ {b[19:16], b[23:20]} ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] h);
        logic [23:0] a;
        a = {h[23:2], 2'b00};
        return {mem(a + 24'd3), mem(a + 24'd2), mem(a + 24'd1), mem(a)};
    endfunction

    function automatic logic [3:0] exp_nib(input int p, input logic [23:0] a);
        logic [7:0] c;
        c = 8'hEB;
        if (p < 8)       return {3'b111, c[7-p]};
        else if (p < 14) return 4'(a >> (4 * (13 - p)));
        else if (p == 14) return TbMode[7:4];
        else             return TbMode[3:0];
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_flash
        localparam int D = (g == 0) ? 4 : 8;
        logic [3:0]  din;
        logic [3:0]  dout;
        int          rcount = 0;
        int          rises_total = 0;
        int          dummy_ok = 0;
        int          last_dummy = 0;
        logic [7:0]  fcmd = 8'h00;
        logic [23:0] fa = 24'h0;
        logic [7:0]  fmode = 8'h00;
        int          k;
        logic [7:0]  b;

        ahb_flash_reader #(
            .DUMMY_CLKS (D),
            .MODE_BYTE  (TbMode)
        ) u_dut (
            .HCLK      (HCLK),
            .HRESETn   (HRESETn),
            .HSEL      (hsel[g]),
            .HADDR     (HADDR),
            .HTRANS    (HTRANS),
            .HWRITE    (HWRITE),
            .HSIZE     (HSIZE),
            .HREADY    (hreadyout[g]),
            .HWDATA    (HWDATA),
            .HREADYOUT (hreadyout[g]),
            .HRESP     (hresp[g]),
            .HRDATA    (hrdata[g]),
            .fr_sck    (sck[g]),
            .fr_ce_n   (ce_n[g]),
            .fr_din    (din),
            .fr_dout   (dout),
            .fr_douten (douten[g])
        );

        always @(posedge sck[g]) rises_total++;

        always @(posedge sck[g] or posedge ce_n[g]) begin
            if (ce_n[g]) begin
                if (rcount != 0) last_dummy = dummy_ok;
                rcount   = 0;
                dummy_ok = 0;
            end else begin
                if (rcount < 8) fcmd = {fcmd[6:0], dout[0]};
                else if (rcount < 14) fa = {fa[19:0], dout};
                else if (rcount < 16) fmode = {fmode[3:0], dout};
                else if (rcount < 16 + D && !douten[g]) dummy_ok++;
                rcount++;
            end
        end

        // Data nibble k is on IO after the k-th data SCK rise.
        always_comb begin
            k   = 0;
            b   = 8'h00;
            din = 4'h0;
            if (rcount >= 17 + D && rcount <= 24 + D) begin
                k   = rcount - 17 - D;
                b   = mem(fa + 24'(k / 2));
                din = k[0] ? b[3:0] : b[7:4];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            if (!HRESETn) begin
                left[i]      = 0;
                last_word[i] = 32'd0;
            end else if (left[i] > 0) begin
                left[i]--;
                if (left[i] == 0) last_word[i] = pend_word[i];
            end else if (hsel[i] && HTRANS[1] && !HWRITE) begin
                left[i]      = W[i];
                pend_addr[i] = {HADDR[23:2], 2'b00};
                pend_word[i] = exp_word(HADDR);
            end
        end
    endtask

    task automatic compare();
        for (int i = 0; i < 2; i++) begin
            int         j;
            logic       busy;
            logic [3:0] dv;
            busy = left[i] > 0;
            j    = W[i] - left[i];
            dv   = (i == 0) ? g_flash[0].dout : g_flash[1].dout;
            chk($sformatf("hresp%0d", i), 32'(hresp[i]), 32'd0);
            chk($sformatf("hreadyout%0d", i), 32'(hreadyout[i]), 32'(!busy));
            chk($sformatf("ce_n%0d", i), 32'(ce_n[i]), 32'(!busy));
            chk($sformatf("sck%0d", i), 32'(sck[i]), 32'(busy && (j % 2 == 1)));
            chk($sformatf("douten%0d", i), 32'(douten[i]), 32'(busy && (j / 2 < 16)));
            chk($sformatf("hrdata%0d", i), hrdata[i], last_word[i]);
            if (busy && (j / 2 < 16)) begin
                chk($sformatf("dout%0d_p%0d", i, j / 2), 32'(dv), 32'(exp_nib(j / 2, pend_addr[i])));
            end
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        model_update();
        @(negedge HCLK);
        compare();
    endtask

    task automatic issue(input int i, input logic [31:0] a, input logic w, input logic [31:0] d);
        hsel    = 2'b00;
        hsel[i] = 1'b1;
        HADDR   = a;
        HTRANS  = 2'b10;
        HWRITE  = w;
        HWDATA  = d;
        tick();
        hsel   = 2'b00;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
    endtask

    task automatic wait_done(input int i, output int waits);
        waits = 0;
        while (hreadyout[i] == 1'b0 && waits < 300) begin
            waits++;
            tick();
        end
        if (waits >= 300) chk("wait_done_timeout", 32'(waits), 32'd0);
    endtask

    initial begin
        int waits;
        int r0, r1, n;
        n_cmp   = 0;
        n_bad   = 0;
        HRESETn = 1'b0;
        hsel    = 2'b00;
        HADDR   = 32'd0;
        HTRANS  = 2'b00;
        HWRITE  = 1'b0;
        HSIZE   = 3'b010;
        HWDATA  = 32'd0;
        W[0]    = 2 * (8 + 6 + 2 + 4 + 8);
        W[1]    = 2 * (8 + 6 + 2 + 8 + 8);
        for (int i = 0; i < 2; i++) begin
            left[i]      = 0;
            last_word[i] = 32'd0;
            pend_addr[i] = 24'd0;
            pend_word[i] = 32'd0;
        end

        repeat (10) tick();
        HRESETn = 1'b1;
        r0 = g_flash[0].rises_total;
        r1 = g_flash[1].rises_total;
        repeat (100) tick();
        chk("idle_sck_rises0", 32'(g_flash[0].rises_total - r0), 32'd0);
        chk("idle_sck_rises1", 32'(g_flash[1].rises_total - r1), 32'd0);

        issue(0, 32'h0000_1234, 1'b0, 32'd0);
        wait_done(0, waits);
        chk("single_waits", 32'(waits), 32'd56);
        chk("single_hrdata", hrdata[0], 32'h4433_2211);
        chk("single_cmd", 32'(g_flash[0].fcmd), 32'h0000_00EB);
        chk("single_addr", 32'(g_flash[0].fa), 32'h0000_1234);
        chk("single_mode", 32'(g_flash[0].fmode), 32'h0000_0000);
        chk("single_dummy", 32'(g_flash[0].last_dummy), 32'd4);
        tick();

        issue(0, 32'h0000_0000, 1'b0, 32'd0);
        wait_done(0, waits);
        chk("b2b_first", hrdata[0], exp_word(32'h0));
        chk("b2b_ce_high_done", 32'(ce_n[0]), 32'd1);
        issue(0, 32'h0000_0004, 1'b0, 32'd0);
        chk("b2b_ce_low_next", 32'(ce_n[0]), 32'd0);
        wait_done(0, waits);
        chk("b2b_second_waits", 32'(waits), 32'd56);
        chk("b2b_second", hrdata[0], exp_word(32'h4));
        tick();

        r0 = g_flash[0].rises_total;
        issue(0, 32'h0000_0010, 1'b1, 32'hDEAD_BEEF);
        chk("write_ready", 32'(hreadyout[0]), 32'd1);
        chk("write_resp", 32'(hresp[0]), 32'd0);
        chk("write_ce_n", 32'(ce_n[0]), 32'd1);
        repeat (5) tick();
        chk("write_no_sck", 32'(g_flash[0].rises_total - r0), 32'd0);

        issue(0, 32'hAB00_1236, 1'b0, 32'd0);
        wait_done(0, waits);
        chk("alias_hrdata", hrdata[0], 32'h4433_2211);
        tick();

        issue(1, 32'h00FF_FFFC, 1'b0, 32'd0);
        wait_done(1, waits);
        chk("d8_waits", 32'(waits), 32'd64);
        chk("d8_hrdata", hrdata[1], exp_word(32'h00FF_FFFC));
        chk("d8_dummy_rises", 32'(g_flash[1].last_dummy), 32'd8);
        chk("d8_addr", 32'(g_flash[1].fa), 32'h00FF_FFFC);
        tick();

        issue(0, 32'h0000_0100, 1'b0, 32'd0);
        n = 0;
        while (g_flash[0].rcount != 24 && n < 200) begin
            tick();
            n++;
        end
        chk("reach_nibble3", 32'(g_flash[0].rcount), 32'd24);
        #2;
        HRESETn = 1'b0;
        #1;
        chk("rst_async_ce_n", 32'(ce_n[0]), 32'd1);
        chk("rst_async_douten", 32'(douten[0]), 32'd0);
        chk("rst_async_sck", 32'(sck[0]), 32'd0);
        chk("rst_async_ready", 32'(hreadyout[0]), 32'd1);
        for (int i = 0; i < 2; i++) begin
            left[i]      = 0;
            last_word[i] = 32'd0;
        end
        repeat (4) tick();
        HRESETn = 1'b1;
        tick();
        issue(0, 32'h0000_1234, 1'b0, 32'd0);
        wait_done(0, waits);
        chk("post_rst_hrdata", hrdata[0], 32'h4433_2211);
        tick();

        for (int t = 0; t < 16; t++) begin
            int          ri;
            logic [31:0] ra;
            ri = $urandom_range(0, 1);
            ra = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                issue(ri, ra, 1'b1, $urandom);
                chk("rand_write_ready", 32'(hreadyout[ri]), 32'd1);
            end else begin
                issue(ri, ra, 1'b0, 32'd0);
                wait_done(ri, waits);
                chk("rand_waits", 32'(waits), 32'(W[ri]));
                chk("rand_hrdata", hrdata[ri], exp_word(ra));
            end
            repeat ($urandom_range(0, 2)) tick();
        end
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
